// File: rtl/serial_transceiver_pkg.sv
// Shared definitions for the serial transceiver slice.
//   DATA_W  : width of the parallel word that is split into chunks
//   state_e : transmit FSM states (IDLE, SHIFT, DONE)
package serial_transceiver_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_transceiver_if.sv
// Bus bundle between a word producer and the serial transceiver.
//   din/sample      : parallel word and its load strobe
//   startTx/clkTx   : transmit request (edge) and transmit tick (level enable)
//   txDone/txBusy   : completion pulse and in-progress flag
//   dout            : chunk currently on the serial output
// master = producer side, slave = transceiver side.
interface serial_transceiver_if #(
  parameter int WIDTH = 4
);
  logic [31:0]      din;
  logic             sample;
  logic             startTx;
  logic             clkTx;
  logic             txDone;
  logic             txBusy;
  logic [WIDTH-1:0] dout;

  modport master (output din, sample, startTx, clkTx, input txDone, txBusy, dout);
  modport slave  (input din, sample, startTx, clkTx, output txDone, txBusy, dout);
endinterface

// File: rtl/st_shift_reg.sv
// Chunk shift register: holds the word being transmitted and presents the
// current chunk on 'chunk'.
//   clk, reset : clock and synchronous active-high reset (clears the word)
//   load       : capture load_data (has priority over shift_en)
//   load_data  : word to transmit
//   shift_en   : advance to the next chunk
//   chunk      : WIDTH-bit chunk currently presented
// Macro SERIAL_TRANSCEIVER_LSB_FIRST_EN selects LSB-first chunk order;
// MSB-first otherwise.
module st_shift_reg
  import serial_transceiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  output logic [WIDTH-1:0]  chunk
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // The presented chunk always sits at one end of the register, so moving
  // to the next chunk is a plain shift by WIDTH toward that end.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
`ifdef SERIAL_TRANSCEIVER_LSB_FIRST_EN
      data_d = data_q >> WIDTH;
`else
      data_d = data_q << WIDTH;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef SERIAL_TRANSCEIVER_LSB_FIRST_EN
  assign chunk = data_q[WIDTH-1:0];
`else
  assign chunk = data_q[DATA_W-1 -: WIDTH];
`endif

endmodule

// File: rtl/serial_transceiver.sv
// Serial transceiver: stores a 32-bit word and, on a startTx rise, sends it
// as DATA_W/WIDTH chunks on dout, advancing one chunk per clkTx-qualified
// clock edge, then pulses txDone for one cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : serial_transceiver_if slave (din, sample, startTx, clkTx,
//                txDone, txBusy, dout)
// Macro SERIAL_TRANSCEIVER_LSB_FIRST_EN selects LSB-first chunk order.
module serial_transceiver
  import serial_transceiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  serial_transceiver_if.slave bus
);

  localparam int         N        = DATA_W / WIDTH;
  localparam logic [5:0] LAST_CNT = 6'(N - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  generate
    if (DATA_W % WIDTH != 0) begin : g_width_check
      $error("serial_transceiver: WIDTH must divide 32");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_q;

  logic              start_rise;
  logic              load;
  logic              shift_en;
  logic [DATA_W-1:0] load_data;
  logic [WIDTH-1:0]  chunk;

  assign start_rise = bus.startTx & ~start_q;

  // A start in the same cycle as a sample transmits the fresh din directly.
  // The final tick does not shift, so dout keeps the last chunk afterwards.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    busy_d    = busy_q;
    done_d    = done_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    load_data = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample) begin
          mem_d = bus.din;
        end
        if (start_rise) begin
          load      = 1'b1;
          load_data = bus.sample ? bus.din : mem_q;
          state_d   = ST_SHIFT;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_SHIFT: begin
        if (bus.clkTx) begin
          if (cnt_q < LAST_CNT) begin
            cnt_d    = cnt_q + 6'd1;
            shift_en = 1'b1;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // The startTx history updates in every state, so a rise during SHIFT or
  // DONE is consumed there instead of being seen later in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= bus.startTx;
    end
  end

  st_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .shift_en (shift_en),
    .chunk    (chunk)
  );

  assign bus.dout   = chunk;
  assign bus.txBusy = busy_q;
  assign bus.txDone = done_q;

endmodule

// File: tb/tb_serial_transceiver.sv
// Bench for serial_transceiver: a WIDTH=4 instance checked against a
// behavioural model every cycle, plus a WIDTH=8 instance for chunk order.
// Honours SERIAL_TRANSCEIVER_LSB_FIRST_EN for expected chunk order.
module tb_serial_transceiver;

  localparam logic [31:0] WORD = 32'hD6E5F198;

`ifdef SERIAL_TRANSCEIVER_LSB_FIRST_EN
  localparam logic [3:0] SEQ [8] = '{4'h8, 4'h9, 4'h1, 4'hF, 4'h5, 4'hE, 4'h6, 4'hD};
`else
  localparam logic [3:0] SEQ [8] = '{4'hD, 4'h6, 4'hE, 4'h5, 4'hF, 4'h1, 4'h9, 4'h8};
`endif

  logic clk = 1'b0;
  logic reset;

  serial_transceiver_if #(.WIDTH(4)) bus ();
  serial_transceiver_if #(.WIDTH(8)) bus8 ();

  serial_transceiver #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  serial_transceiver #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus8)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the WIDTH=4 instance: phase 0 idle, 1 sending,
  // 2 done; dout derived arithmetically from the word and chunk index.
  logic [31:0] m_mem, m_word, m_dout;
  int          m_phase, m_idx;
  logic        m_prev;

  function automatic logic [31:0] chunkOf(logic [31:0] word, int k, int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
`ifdef SERIAL_TRANSCEIVER_LSB_FIRST_EN
    return (word >> (k * w)) & mask;
`else
    return (word >> (32 - (k + 1) * w)) & mask;
`endif
  endfunction

  task automatic modelStep();
    logic rise;
    rise = bus.startTx && !m_prev;
    if (reset) begin
      m_mem = '0; m_word = '0; m_dout = '0;
      m_phase = 0; m_idx = 0; m_prev = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (rise) begin
            m_word  = bus.sample ? bus.din : m_mem;
            m_idx   = 0;
            m_phase = 1;
            m_dout  = chunkOf(m_word, 0, 4);
          end
          if (bus.sample) m_mem = bus.din;
        end
        1: begin
          if (bus.clkTx) begin
            if (m_idx < 7) begin
              m_idx  = m_idx + 1;
              m_dout = chunkOf(m_word, m_idx, 4);
            end else begin
              m_phase = 2;
            end
          end
        end
        default: m_phase = 0;
      endcase
      m_prev = bus.startTx;
    end
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic rst, logic [31:0] d, logic smp, logic st, logic tick);
    reset       = rst;
    bus.din     = d;
    bus.sample  = smp;
    bus.startTx = st;
    bus.clkTx   = tick;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("model dout", 32'(bus.dout), m_dout);
    checkOutput("model busy", 32'(bus.txBusy), 32'(m_phase == 1));
    checkOutput("model done", 32'(bus.txDone), 32'(m_phase == 2));
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] din;
    logic        smp;
    logic        st;
    logic        tick;
    logic [3:0]  e_dout;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  int busy_cycles;
  int done_cnt;

  initial begin
    reset = 1'b1;
    bus.din = '0; bus.sample = 1'b0; bus.startTx = 1'b0; bus.clkTx = 1'b0;
    bus8.din = '0; bus8.sample = 1'b0; bus8.startTx = 1'b0; bus8.clkTx = 1'b0;
    m_mem = '0; m_word = '0; m_dout = '0; m_phase = 0; m_idx = 0; m_prev = 1'b0;

    // Reset, load, start, eight ticks, done pulse, startTx held high.
    vecs.push_back('{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, WORD,  1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, SEQ[0], 1'b1, 1'b0});
    for (int k = 1; k < 8; k++)
      vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, SEQ[k], 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, SEQ[7], 1'b0, 1'b1});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, SEQ[7], 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, SEQ[7], 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, SEQ[7], 1'b0, 1'b0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].smp, vecs[i].st, vecs[i].tick);
      stepCycle();
      checkOutput($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].e_dout));
      checkOutput($sformatf("vec%0d busy", i), 32'(bus.txBusy), 32'(vecs[i].e_busy));
      checkOutput($sformatf("vec%0d done", i), 32'(bus.txDone), 32'(vecs[i].e_done));
      #3;
    end

    // Gated ticks: clkTx every 3rd cycle from the 4th edge after the start.
    applyStimulus(1'b0, WORD, 1'b1, 1'b0, 1'b0);
    stepCycle();
    busy_cycles = 0;
    done_cnt    = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, (c >= 4) && ((c - 4) % 3 == 0));
      stepCycle();
      if (bus.txBusy) busy_cycles++;
      if (bus.txDone) done_cnt++;
    end
    checkOutput("gated busy cycles", 32'(busy_cycles), 32'd25);
    checkOutput("gated done pulses", 32'(done_cnt), 32'd1);

    // Protected load: samples of all-ones during SHIFT and DONE are ignored.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("prot first chunk", 32'(bus.dout), chunkOf(WORD, 0, 4));
    for (int t = 0; t < 10; t++) begin
      applyStimulus(1'b0, 32'hFFFF_FFFF, t <= 8, 1'b1, 1'b1);
      stepCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("prot second chunk0", 32'(bus.dout), chunkOf(WORD, 0, 4));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("prot second chunk1", 32'(bus.dout), chunkOf(WORD, 1, 4));
    stepCycle();

    // Reset mid-SHIFT: immediate idle, dout cleared, no done pulse later.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("abort dout", 32'(bus.dout), 32'h0);
    checkOutput("abort busy", 32'(bus.txBusy), 32'h0);
    checkOutput("abort done", 32'(bus.txDone), 32'h0);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("abort no done", 32'(bus.txDone), 32'h0);
    end

    // WIDTH=8 instance: four byte chunks in the configured order.
    bus8.din = WORD; bus8.sample = 1'b1;
    stepCycle();
    bus8.sample = 1'b0; bus8.startTx = 1'b1;
    stepCycle();
    checkOutput("w8 chunk0", 32'(bus8.dout), chunkOf(WORD, 0, 8));
    checkOutput("w8 busy", 32'(bus8.txBusy), 32'h1);
    bus8.clkTx = 1'b1;
    for (int k = 1; k < 4; k++) begin
      stepCycle();
      checkOutput($sformatf("w8 chunk%0d", k), 32'(bus8.dout), chunkOf(WORD, k, 8));
    end
    stepCycle();
    checkOutput("w8 end busy", 32'(bus8.txBusy), 32'h0);
    checkOutput("w8 end done", 32'(bus8.txDone), 32'h1);
    checkOutput("w8 end dout", 32'(bus8.dout), chunkOf(WORD, 3, 8));
    bus8.clkTx = 1'b0; bus8.startTx = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom, $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 5) == 0) ? ~bus.startTx : bus.startTx,
                    $urandom_range(0, 1) == 1);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
